// File: rtl/pp_acc_pkg.sv
// Shared constants, state encoding and datatypes for the partial-product column accumulator.
package pp_acc_pkg;

    localparam int DIGIT_W      = 79;
    localparam int HI_W         = 2;
    localparam int GUARD_W      = 8;
    localparam int ACC_W        = DIGIT_W + HI_W + GUARD_W;
    localparam int NUM_COLS_DEF = 39;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH,
        DONE
    } state_t;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [ACC_W-1:0]   acc_t;
    typedef logic [HI_W-1:0]    hi_t;

    // The {hi, mid} slices form one partial product, zero-extended into the guard bits.
    function automatic acc_t beat_value(input hi_t hi, input digit_t mid);
        return acc_t'({hi, mid});
    endfunction

endpackage

// File: rtl/pp_out_reg.sv
// Single-entry valid/ready holding register for the emitted result digit and its last flag.
module pp_out_reg
    import pp_acc_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  digit_t load_digit,
    input  logic   load_last,
    input  logic   out_ready,
    output logic   out_valid,
    output digit_t out_digit,
    output logic   out_last,
    output logic   slot_free
);

    logic   valid_q, valid_d;
    digit_t digit_q, digit_d;
    logic   last_q, last_d;

    // A load may coincide with the handshake of the previous digit; the new one replaces it.
    always_comb begin
        valid_d = valid_q;
        digit_d = digit_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            digit_d = load_digit;
            last_d  = load_last;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            digit_q <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            digit_q <= digit_d;
            last_q  <= last_d;
        end
    end

    assign slot_free = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_digit = digit_q;
    assign out_last  = last_q;

endmodule

// File: rtl/pp_column_accumulator.sv
// Sums partial products per result column, ripples the carry into the next column and emits
// one digit per column plus a final carry digit. Optional PP_ACC_OVERFLOW_CHECK_EN adds a sticky overflow flag.
module pp_column_accumulator
    import pp_acc_pkg::*;
#(
    parameter int NUM_COLS = NUM_COLS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [HI_W-1:0]    res_hi,
    input  logic [DIGIT_W-1:0] res_mid,
    input  logic               col_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIGIT_W-1:0] out_digit,
    output logic               out_last,
    output logic               busy,
    output logic               overflow
);

    localparam int COL_W = $clog2(NUM_COLS + 1);

    state_t           state_q, state_d;
    acc_t             acc_q, acc_d;
    acc_t             beat, sum;
    logic [COL_W-1:0] col_q, col_d;
    logic             slot_free;
    logic             beat_acc;
    logic             last_col;
    logic             load;
    logic             load_last;
    digit_t           load_digit;

    assign beat     = beat_value(res_hi, res_mid);
    assign beat_acc = in_valid && in_ready;
    assign last_col = (col_q == COL_W'(NUM_COLS - 1));

`ifdef PP_ACC_OVERFLOW_CHECK_EN
    logic [ACC_W:0] sum_ext;
    logic           ovf_q, ovf_d;

    assign sum_ext = {1'b0, acc_q} + {1'b0, beat};
    assign sum     = sum_ext[ACC_W-1:0];

    // Sticky across the whole product; only a new start or reset clears it.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == IDLE && en) begin
            ovf_d = 1'b0;
        end else if (beat_acc && sum_ext[ACC_W]) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign sum      = acc_q + beat;
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = ACCUM;
            ACCUM:   if (beat_acc && col_last && last_col) state_d = FLUSH;
            FLUSH:   if (slot_free) state_d = DONE;
            DONE:    if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Closing a column hands the low digit to the output register and keeps only the carry.
    always_comb begin
        acc_d      = acc_q;
        col_d      = col_q;
        load       = 1'b0;
        load_last  = 1'b0;
        load_digit = '0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    acc_d = '0;
                    col_d = '0;
                end
            end
            ACCUM: begin
                if (beat_acc) begin
                    if (col_last) begin
                        load       = 1'b1;
                        load_digit = sum[DIGIT_W-1:0];
                        acc_d      = sum >> DIGIT_W;
                        col_d      = col_q + COL_W'(1);
                    end else begin
                        acc_d = sum;
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_last  = 1'b1;
                    load_digit = acc_q[DIGIT_W-1:0];
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    acc_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ACCUM) && slot_free;
        busy     = (state_q != IDLE);
    end

    pp_out_reg u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_digit (load_digit),
        .load_last  (load_last),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_digit  (out_digit),
        .out_last   (out_last),
        .slot_free  (slot_free)
    );

endmodule

// File: tb/tb_pp_column_accumulator.sv
// Randomized and directed bench for pp_column_accumulator, scored against a plain-arithmetic model.
module tb_pp_column_accumulator;

    localparam int NC = 3;
    localparam logic [78:0] ONES = 79'h7FFF_FFFF_FFFF_FFFF_FFFF;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        en        = 1'b0;
    logic        in_valid  = 1'b0;
    logic        col_last  = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  res_hi    = '0;
    logic [78:0] res_mid   = '0;
    logic        in_ready, out_valid, out_last, busy, overflow;
    logic [78:0] out_digit;

    pp_column_accumulator #(.NUM_COLS(NC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_hi    (res_hi),
        .res_mid   (res_mid),
        .col_last  (col_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  hi;
        logic [78:0] mid;
        logic        last;
    } beat_t;

    beat_t       plan[$];
    logic [78:0] model_digits[$];
    logic [78:0] exp_dig[$];
    logic        exp_lst[$];
    logic        exp_ovf     = 1'b0;
    int          checks      = 0;
    int          failures    = 0;
    int          ready_mode  = 0;
    logic        lat_mode    = 1'b0;
    int          lat_idx     = 0;
    logic        lat_pending = 1'b0;
    logic [78:0] lat_exp     = '0;
    logic        held_valid  = 1'b0;
    logic [78:0] held_digit  = '0;
    logic        held_last   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_beat(input logic [1:0] hi, input logic [78:0] mid, input logic last);
        beat_t b;
        b.hi   = hi;
        b.mid  = mid;
        b.last = last;
        plan.push_back(b);
    endtask

    // Model: the running column sum lives in an 89-bit register (wraps, flagging overflow);
    // closing a column emits sum mod 2^79 and keeps sum / 2^79; the leftover carry is the final digit.
    task automatic run_model();
        logic [127:0] acc;
        logic [127:0] lim;
        acc     = '0;
        lim     = 128'd1 << 89;
        exp_ovf = 1'b0;
        model_digits.delete();
        foreach (plan[i]) begin
            acc = acc + 128'({plan[i].hi, plan[i].mid});
            if (acc >= lim) begin
                exp_ovf = 1'b1;
                acc     = acc - lim;
            end
            if (plan[i].last) begin
                model_digits.push_back(acc[78:0]);
                exp_dig.push_back(acc[78:0]);
                exp_lst.push_back(1'b0);
                acc = acc >> 79;
            end
        end
        model_digits.push_back(acc[78:0]);
        exp_dig.push_back(acc[78:0]);
        exp_lst.push_back(1'b1);
    endtask

    function automatic logic want_ovf();
`ifdef PP_ACC_OVERFLOW_CHECK_EN
        return exp_ovf;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Per-cycle checker: digit scoreboard, output hold under stall, in_ready backpressure, latency.
    always @(negedge clk) begin
        logic [78:0] d;
        logic        l;
        if (!rst_n) begin
            held_valid  = 1'b0;
            lat_pending = 1'b0;
        end else begin
            if (lat_pending) begin
                check("latency_valid", 128'(out_valid), 128'(1'b1));
                check("latency_digit", 128'(out_digit), 128'(lat_exp));
                lat_pending = 1'b0;
            end
            if (held_valid)
                check("hold_stable", 128'({out_valid, out_last, out_digit}),
                      128'({1'b1, held_last, held_digit}));
            if (out_valid && !out_ready) begin
                check("backpressure_in_ready", 128'(in_ready), 128'(1'b0));
                held_valid = 1'b1;
                held_digit = out_digit;
                held_last  = out_last;
            end else begin
                held_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_dig.size() == 0) begin
                    failures++;
                    $display("FAIL extra_digit actual=%0h required=none", out_digit);
                end else begin
                    d = exp_dig.pop_front();
                    l = exp_lst.pop_front();
                    if (out_digit !== d) begin
                        failures++;
                        $display("FAIL digit actual=%0h required=%0h", out_digit, d);
                    end
                    check("digit_last", 128'(out_last), 128'(l));
                end
            end
            if (lat_mode && in_valid && in_ready && col_last && lat_idx < model_digits.size()) begin
                lat_pending = 1'b1;
                lat_exp     = model_digits[lat_idx];
                lat_idx++;
            end
        end
    end

    task automatic run_product(input int n_drive, input bit gaps, input bit pulse_en);
        bit ok;
        run_model();
        lat_idx = 0;
        @(posedge clk);
        #1 en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        check("busy_after_en", 128'(busy), 128'(1'b1));
        check("overflow_cleared_by_en", 128'(overflow), 128'(1'b0));
        @(posedge clk);
        #1;
        for (int j = 0; j < n_drive; j++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            res_hi   = plan[j].hi;
            res_mid  = plan[j].mid;
            col_last = plan[j].last;
            in_valid = 1'b1;
            if (pulse_en && j == 1) en = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            col_last = 1'b0;
            en       = 1'b0;
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL beat_accept_timeout actual=in_ready_low required=accept");
                return;
            end
        end
        if (n_drive == plan.size()) begin
            ok = 1'b0;
            for (int k = 0; k < 500; k++) begin
                @(negedge clk);
                if (!busy) begin
                    ok = 1'b1;
                    break;
                end
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL done_timeout actual=busy required=idle");
            end
            check("digits_outstanding", 128'(exp_dig.size()), 128'(0));
            check("overflow_end", 128'(overflow), 128'(want_ovf()));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyCarryPlan();
        plan.delete();
        push_beat(2'd3, ONES, 1'b0);
        push_beat(2'd3, ONES, 1'b1);
        push_beat(2'd0, 79'd5, 1'b1);
        push_beat(2'd0, 79'd0, 1'b1);
    endtask

    initial begin
        bit seen;
        logic [95:0] r;
        #12;
        check("reset_outputs", 128'({in_ready, out_valid, out_last, busy, overflow, out_digit}), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Carry propagation across columns
        ready_mode = 0;
        applyCarryPlan();
        run_product(plan.size(), 1'b0, 1'b0);
        check("model_carry_d0", 128'(model_digits[0]), 128'(79'h7FFF_FFFF_FFFF_FFFF_FFFE));
        check("model_carry_d1", 128'(model_digits[1]), 128'(79'd12));
        check("model_carry_final", 128'(model_digits[3]), 128'(79'd0));

        // Backpressure: stall the consumer for 5 cycles once the first digit is pending
        @(negedge clk);
        ready_mode = 2;
        applyCarryPlan();
        fork
            run_product(plan.size(), 1'b0, 1'b0);
            begin
                seen = 1'b0;
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                repeat (5) @(negedge clk);
                check("bp_first_digit_pending", 128'({seen, out_valid, out_digit}),
                      128'({2'b11, 79'h7FFF_FFFF_FFFF_FFFF_FFFE}));
                check("bp_in_ready_low", 128'(in_ready), 128'(1'b0));
                ready_mode = 0;
            end
        join

        // Back-to-back single-beat columns, one cycle latency each
        plan.delete();
        push_beat(2'd0, 79'd1, 1'b1);
        push_beat(2'd0, 79'd2, 1'b1);
        push_beat(2'd0, 79'd3, 1'b1);
        lat_mode = 1'b1;
        run_product(plan.size(), 1'b0, 1'b0);
        lat_mode = 1'b0;
        check("model_b2b_d2", 128'(model_digits[2]), 128'(79'd3));
        check("b2b_latency_seen", 128'(lat_idx), 128'(3));

        // Reset in the middle of a product, then a clean restart
        applyCarryPlan();
        run_product(2, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outputs", 128'({in_ready, out_valid, out_last, busy, overflow, out_digit}), 128'(0));
        exp_dig.delete();
        exp_lst.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        plan.delete();
        push_beat(2'd0, 79'd5, 1'b1);
        push_beat(2'd0, 79'd6, 1'b1);
        push_beat(2'd0, 79'd7, 1'b1);
        run_product(plan.size(), 1'b0, 1'b0);

        // en pulsed while busy must not restart the product
        applyCarryPlan();
        run_product(plan.size(), 1'b0, 1'b1);

        // 257 maximal beats in one column overflow the 89-bit accumulator
        plan.delete();
        for (int i = 0; i < 257; i++) push_beat(2'd3, ONES, (i == 256));
        push_beat(2'd0, 79'd1, 1'b1);
        push_beat(2'd0, 79'd2, 1'b1);
        run_product(plan.size(), 1'b0, 1'b0);
        check("model_overflow", 128'(exp_ovf), 128'(1'b1));
        check("model_overflow_d0", 128'(model_digits[0]), 128'((128'd1 << 79) - 128'd257));
        repeat (3) @(negedge clk);
        check("overflow_sticky", 128'(overflow), 128'(want_ovf()));

        // Randomized products with random gaps and random consumer stalls
        ready_mode = 1;
        for (int p = 0; p < 20; p++) begin
            plan.delete();
            for (int c = 0; c < NC; c++) begin
                int nb;
                nb = $urandom_range(1, 4);
                for (int b = 0; b < nb; b++) begin
                    r = {$urandom(), $urandom(), $urandom()};
                    push_beat(2'($urandom_range(0, 3)), r[78:0], (b == nb - 1));
                end
            end
            run_product(plan.size(), 1'b1, 1'b0);
        end
        ready_mode = 0;

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 128'(exp_dig.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
